// File: rtl/result_writeback_ctrl.sv
// Drains aligned result rows from the two Align_fifo halves into BRAM_OM32, one element per cycle.
// Build option WB_RELU_EN: negative elements are written as zero.
module result_writeback_ctrl #(
  parameter int          LANES       = 8,
  parameter int          DW          = 32,
  parameter logic [31:0] SADDR_O_MEM = 32'h0,
  parameter logic [31:0] O_MEM_INCR  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_start,
  input  logic [7:0]          sub_M,
  input  logic [7:0]          sub_P,
  input  logic [15:0]         subOM_addr,
  input  logic [15:0]         subOM_incr,
  output logic                wb_finish,
  input  logic                fifo1_empty,
  output logic                fifo1_rd_en,
  input  logic [LANES*DW-1:0] fifo1_rddata,
  input  logic                fifo2_empty,
  output logic                fifo2_rd_en,
  input  logic [LANES*DW-1:0] fifo2_rddata,
  output logic [31:0]         BRAM_OM32_addr,
  output logic                BRAM_OM32_clk,
  output logic [DW-1:0]       BRAM_OM32_wrdata,
  output logic                BRAM_OM32_en,
  output logic                BRAM_OM32_rst,
  output logic [3:0]          BRAM_OM32_we
);

  typedef enum logic [3:0] {
    IDLE, INFO, POP1, LAT1, WR1, POP2, LAT2, WR2, NEXT, FINISH
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          m_total, m_cnt;
  logic [3:0]          p1, p2, p_cnt;
  logic [3:0]          p1_in, p2_in;
  logic [7:0]          p_clamp;
  logic [31:0]         row_base, row_stride;
  logic [LANES*DW-1:0] row_buf;
  logic [DW-1:0]       lane_val, wr_val;
  logic [3:0]          col;

  assign BRAM_OM32_clk = clk;
  assign BRAM_OM32_rst = rst;
  assign BRAM_OM32_en  = 1'b1;

  // Split the (clamped) column count between the two FIFO halves.
  assign p_clamp = (sub_P > 8'd16) ? 8'd16 : sub_P;
  assign p1_in   = (sub_P >= 8'd8) ? 4'd8 : sub_P[3:0];
  assign p2_in   = (sub_P > 8'd8) ? 4'(p_clamp - 8'd8) : 4'd0;

  assign col = (state == WR2) ? {1'b1, p_cnt[2:0]} : {1'b0, p_cnt[2:0]};

  always_comb begin
    lane_val = row_buf[int'(p_cnt[2:0])*DW +: DW];
`ifdef WB_RELU_EN
    wr_val = lane_val[DW-1] ? '0 : lane_val;
`else
    wr_val = lane_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pops are combinational so they can never coincide with an empty flag in the same cycle.
  always_comb begin
    state_nxt   = state;
    fifo1_rd_en = 1'b0;
    fifo2_rd_en = 1'b0;
    case (state)
      IDLE:   if (wb_start) state_nxt = INFO;
      INFO:   state_nxt = (sub_M == 8'd0 || p1_in == 4'd0) ? FINISH : POP1;
      POP1:   if (!fifo1_empty) begin
                fifo1_rd_en = 1'b1;
                state_nxt   = LAT1;
              end
      LAT1:   state_nxt = WR1;
      WR1:    if (p_cnt == p1 - 4'd1) state_nxt = (p2 != 4'd0) ? POP2 : NEXT;
      POP2:   if (!fifo2_empty) begin
                fifo2_rd_en = 1'b1;
                state_nxt   = LAT2;
              end
      LAT2:   state_nxt = WR2;
      WR2:    if (p_cnt == p2 - 4'd1) state_nxt = NEXT;
      NEXT:   state_nxt = (m_cnt == m_total - 8'd1) ? FINISH : POP1;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_total          <= '0;
      m_cnt            <= '0;
      p1               <= '0;
      p2               <= '0;
      p_cnt            <= '0;
      row_base         <= '0;
      row_stride       <= '0;
      row_buf          <= '0;
      wb_finish        <= 1'b0;
      BRAM_OM32_addr   <= '0;
      BRAM_OM32_wrdata <= '0;
      BRAM_OM32_we     <= '0;
    end else begin
      BRAM_OM32_we <= 4'h0;
      wb_finish    <= (state == FINISH);
      case (state)
        INFO: begin
          m_total    <= sub_M;
          p1         <= p1_in;
          p2         <= p2_in;
          m_cnt      <= '0;
          row_base   <= SADDR_O_MEM + 32'(subOM_addr) * O_MEM_INCR;
          row_stride <= 32'(subOM_incr) * O_MEM_INCR;
        end
        LAT1: begin
          row_buf <= fifo1_rddata;
          p_cnt   <= '0;
        end
        LAT2: begin
          row_buf <= fifo2_rddata;
          p_cnt   <= '0;
        end
        WR1, WR2: begin
          BRAM_OM32_addr   <= row_base + 32'(col) * O_MEM_INCR;
          BRAM_OM32_wrdata <= wr_val;
          BRAM_OM32_we     <= 4'hf;
          p_cnt            <= p_cnt + 4'd1;
        end
        NEXT: begin
          row_base <= row_base + row_stride;
          m_cnt    <= m_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writeback_ctrl.sv
// Self-checking bench for result_writeback_ctrl: FIFO models feed rows, a scoreboard of
// expected BRAM writes is built from the column/row address rules.
module tb_result_writeback_ctrl;

  logic         clk, rst, wb_start;
  logic [7:0]   sub_M, sub_P;
  logic [15:0]  subOM_addr, subOM_incr;
  logic         wb_finish;
  logic         fifo1_empty, fifo1_rd_en, fifo2_empty, fifo2_rd_en;
  logic [255:0] fifo1_rddata, fifo2_rddata;
  logic [31:0]  BRAM_OM32_addr, BRAM_OM32_wrdata;
  logic         BRAM_OM32_clk, BRAM_OM32_en, BRAM_OM32_rst;
  logic [3:0]   BRAM_OM32_we;

  int           vectors = 0;
  int           miscompares = 0;
  int           writesSeen = 0;
  int           cnt1 = 0, cnt2 = 0;
  logic         hold1 = 1'b0;
  logic [255:0] q1[$], q2[$];
  logic [31:0]  expAddr[$], expData[$];

  result_writeback_ctrl dut (
    .clk(clk), .rst(rst), .wb_start(wb_start),
    .sub_M(sub_M), .sub_P(sub_P), .subOM_addr(subOM_addr), .subOM_incr(subOM_incr),
    .wb_finish(wb_finish),
    .fifo1_empty(fifo1_empty), .fifo1_rd_en(fifo1_rd_en), .fifo1_rddata(fifo1_rddata),
    .fifo2_empty(fifo2_empty), .fifo2_rd_en(fifo2_rd_en), .fifo2_rddata(fifo2_rddata),
    .BRAM_OM32_addr(BRAM_OM32_addr), .BRAM_OM32_clk(BRAM_OM32_clk),
    .BRAM_OM32_wrdata(BRAM_OM32_wrdata), .BRAM_OM32_en(BRAM_OM32_en),
    .BRAM_OM32_rst(BRAM_OM32_rst), .BRAM_OM32_we(BRAM_OM32_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo1_empty = hold1 || (cnt1 == 0);
  assign fifo2_empty = (cnt2 == 0);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] reluRef(input logic [31:0] v);
`ifdef WB_RELU_EN
    return ($signed(v) < 0) ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] laneVal(input int pattern, input int r, input int c);
    if (pattern == 1) return 32'(r * 16 + c + 1);
    if (pattern == 2) begin
      case (c)
        0: return 32'hFFFF_FFFB;
        1: return 32'd7;
        2: return 32'h8000_0000;
        3: return 32'h0;
        default: return $urandom;
      endcase
    end
    return $urandom;
  endfunction

  // FIFO models with one-cycle read latency.
  always @(posedge clk) begin
    if (fifo1_rd_en && q1.size() > 0) begin
      fifo1_rddata <= q1.pop_front();
      cnt1 <= cnt1 - 1;
    end
    if (fifo2_rd_en && q2.size() > 0) begin
      fifo2_rddata <= q2.pop_front();
      cnt2 <= cnt2 - 1;
    end
  end

  // Scoreboard for BRAM writes and pop legality.
  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      if (fifo1_rd_en) checkOutput("rd1_while_empty", 32'(fifo1_empty), 32'd0);
      if (fifo2_rd_en) checkOutput("rd2_while_empty", 32'(fifo2_empty), 32'd0);
      if (BRAM_OM32_we != 4'h0) begin
        writesSeen++;
        checkOutput("we_value", 32'(BRAM_OM32_we), 32'hf);
        if (expAddr.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
        else begin
          checkOutput("wr_addr", BRAM_OM32_addr, expAddr.pop_front());
          checkOutput("wr_data", BRAM_OM32_wrdata, expData.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input int m, input int p, input logic [15:0] addr,
                               input logic [15:0] incr, input int pattern,
                               input int stall, input int abortAt);
    int           pc, p1, p2, n, lat;
    logic [255:0] r1, r2;
    logic [31:0]  v, a;
    bit           done, aborted;
    pc = (p > 16) ? 16 : p;
    p1 = (pc > 8) ? 8 : pc;
    p2 = pc - p1;
    q1.delete(); q2.delete(); expAddr.delete(); expData.delete();
    for (int r = 0; r < m; r++) begin
      r1 = '0;
      r2 = '0;
      for (int c = 0; c < 16; c++) begin
        v = laneVal(pattern, r, c);
        if (c < 8) r1[c*32 +: 32] = v;
        else       r2[(c-8)*32 +: 32] = v;
        if (c < pc) begin
          a = (32'(addr) + 32'(r) * 32'(incr) + 32'(c)) * 32'd4;
          expAddr.push_back(a);
          expData.push_back(reluRef(v));
        end
      end
      if (p1 > 0) q1.push_back(r1);
      if (p2 > 0) q2.push_back(r2);
    end
    cnt1 = q1.size();
    cnt2 = q2.size();
    writesSeen = 0;
    hold1 = (stall > 0);
    @(negedge clk);
    wb_start = 1'b1;
    sub_M = 8'(m);
    sub_P = 8'(p);
    subOM_addr = addr;
    subOM_incr = incr;
    n = 0;
    done = 0;
    aborted = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) wb_start = 1'b0;
      if (n == 2) begin
        sub_M = 8'($urandom);
        sub_P = 8'($urandom);
        subOM_addr = 16'($urandom);
        subOM_incr = 16'($urandom);
      end
      if (n == 4) wb_start = 1'b1;
      if (n == 5) wb_start = 1'b0;
      if (stall > 0) begin
        if (hold1) begin
          checkOutput("stall_rd_en", 32'(fifo1_rd_en), 32'd0);
          checkOutput("stall_we", 32'(BRAM_OM32_we), 32'd0);
        end
        if (n >= stall) hold1 = 1'b0;
      end
      if (abortAt > 0 && writesSeen >= abortAt) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_we", 32'(BRAM_OM32_we), 32'd0);
        checkOutput("abort_addr", BRAM_OM32_addr, 32'd0);
        checkOutput("abort_wrdata", BRAM_OM32_wrdata, 32'd0);
        checkOutput("abort_rd1", 32'(fifo1_rd_en), 32'd0);
        checkOutput("abort_rd2", 32'(fifo2_rd_en), 32'd0);
        repeat (3) begin
          @(negedge clk);
          checkOutput("abort_no_finish", 32'(wb_finish), 32'd0);
        end
        rst = 1'b0;
        q1.delete(); q2.delete(); expAddr.delete(); expData.delete();
        cnt1 = 0;
        cnt2 = 0;
        aborted = 1;
        done = 1;
      end else if (wb_finish) done = 1;
    end
    wb_start = 1'b0;
    hold1 = 1'b0;
    if (aborted) return;
    if (!done) checkOutput("finish_timeout", 32'd0, 32'd1);
    else begin
      if (stall == 0 && (m <= 1 || p == 0)) begin
        lat = (m == 0 || p1 == 0) ? 3 : 2 + 3 + p1 + ((p2 > 0) ? 2 + p2 : 0) + 1;
        checkOutput("latency", 32'(n), 32'(lat));
      end
      @(negedge clk);
      checkOutput("finish_pulse_width", 32'(wb_finish), 32'd0);
    end
    checkOutput("writes_missing", 32'(expAddr.size()), 32'd0);
    checkOutput("fifo1_left", 32'(cnt1), 32'd0);
    checkOutput("fifo2_left", 32'(cnt2), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    wb_start = 1'b0;
    sub_M = '0;
    sub_P = '0;
    subOM_addr = '0;
    subOM_incr = '0;
    fifo1_rddata = '0;
    fifo2_rddata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_we", 32'(BRAM_OM32_we), 32'd0);
    checkOutput("rst_addr", BRAM_OM32_addr, 32'd0);
    checkOutput("rst_wrdata", BRAM_OM32_wrdata, 32'd0);
    checkOutput("rst_finish", 32'(wb_finish), 32'd0);
    checkOutput("rst_bram_en", 32'(BRAM_OM32_en), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1, 8, 16'd0, 16'd0, 1, 0, 0);
    applyStimulus(2, 12, 16'd4, 16'd16, 0, 0, 0);
    applyStimulus(1, 12, 16'd100, 16'd0, 0, 0, 0);
    applyStimulus(2, 8, 16'd7, 16'd3, 0, 12, 0);
    applyStimulus(0, 9, 16'd5, 16'd5, 0, 0, 0);
    applyStimulus(3, 0, 16'd5, 16'd5, 0, 0, 0);
    applyStimulus(1, 20, 16'd50, 16'd0, 0, 0, 0);
    applyStimulus(1, 16, 16'd50, 16'd0, 0, 0, 0);
    applyStimulus(1, 4, 16'd200, 16'd0, 2, 0, 0);
    applyStimulus(2, 12, 16'd4, 16'd16, 0, 0, 9);
    applyStimulus(2, 12, 16'd4, 16'd16, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(0, 20)),
                    16'($urandom), 16'($urandom), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
